// File: rtl/ula_multiciclo.sv
// Multi-cycle ALU: single-edge logic/arithmetic/shift ops plus an unsigned
// shift-add multiplier taking WIDTH cycles, sequenced by an IDLE/MUL/DONE FSM.
module ula_multiciclo #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Overflow,
  output logic             SLT_out,
  output logic             busy,
  output logic             done
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST_STEP = SHW'(WIDTH - 1);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_SLT = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_NOR = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b0111;
  localparam logic [3:0] OP_SRL = 4'b1000;
  localparam logic [3:0] OP_SRA = 4'b1001;
  localparam logic [3:0] OP_MUL = 4'b1010;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 zero_q, zero_d;
  logic                 ovf_q, ovf_d;
  logic                 slt_q, slt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [SHW-1:0]       cnt_q, cnt_d;

  logic [WIDTH-1:0]     sum, diff, alu_res;
  logic [SHW-1:0]       shamt;
  logic                 add_ovf, sub_ovf, lt, alu_ovf, alu_valid;
  logic [2*WIDTH-1:0]   acc_step;

  assign sum     = A + B;
  assign diff    = A - B;
  assign shamt   = B[SHW-1:0];
  assign add_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
  assign sub_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
  assign lt      = diff[WIDTH-1] ^ sub_ovf;

  // Single-edge datapath; unknown codes yield zero with every flag clear.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    alu_res   = '0;
    alu_ovf   = 1'b0;
    alu_valid = 1'b1;
    case (ALUControl)
      OP_ADD: begin alu_res = sum;  alu_ovf = add_ovf; end
      OP_SUB: begin alu_res = diff; alu_ovf = sub_ovf; end
      OP_AND: alu_res = A & B;
      OP_OR:  alu_res = A | B;
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, lt};
      OP_XOR: alu_res = A ^ B;
      OP_NOR: alu_res = ~(A | B);
      OP_SLL: alu_res = A << shamt;
      OP_SRL: alu_res = A >> shamt;
      OP_SRA: alu_res = $unsigned($signed(A) >>> shamt);
      default: alu_valid = 1'b0;
    endcase
  end

  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    slt_d    = slt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (ALUControl == OP_MUL) begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, A};
            mplier_d = B;
            cnt_d    = '0;
            state_d  = S_MUL;
          end else begin
            result_d = alu_res;
            zero_d   = alu_valid && (alu_res == '0);
            ovf_d    = alu_ovf;
            if (ALUControl == OP_SLT) slt_d = lt;
            state_d  = S_DONE;
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SHW'(1);
        if (cnt_q == LAST_STEP) begin
          result_d = acc_step[WIDTH-1:0];
          zero_d   = (acc_step[WIDTH-1:0] == '0);
          ovf_d    = |acc_step[2*WIDTH-1:WIDTH];
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (reset) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      slt_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      slt_q    <= slt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign Result   = result_q;
  assign Zero     = zero_q;
  assign Overflow = ovf_q;
  assign SLT_out  = slt_q;
  assign busy     = (state_q == S_MUL);
  assign done     = (state_q == S_DONE);

endmodule
